// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the bit-counter width sized for the largest supported operand width.
package serial_adder_ctrl_pkg;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned CNT_W     = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder used by serial_adder_ctrl, one bit per cycle.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carryOut
);

  always_comb begin
    sum      = a ^ b ^ c;
    carryOut = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder bit per cycle, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             carryIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_in_ready;
  logic             r_out_valid;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  serial_fa_cell u_fa (
    .a        (r_a[0]),
    .b        (r_b[0]),
    .c        (r_carry),
    .sum      (w_s),
    .carryOut (w_co)
  );

  // Shift-in at the MSB written without a part-select so WIDTH=1 stays legal.
  always_comb begin
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    w_acc_next = (r_acc >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  end

  // The accumulator shifts while busy; sum/carryOut only take the final value,
  // so the visible result stays at the previous one until DONE.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_co        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (inValid && r_in_ready) begin
            r_a        <= opA;
            r_b        <= opB;
            r_carry    <= carryIn;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_acc   <= w_acc_next;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum       <= w_acc_next;
            r_co        <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= r_carry ^ w_co;
`endif
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    inReady  = r_in_ready;
    outValid = r_out_valid;
    sum      = r_sum;
    carryOut = r_co;
`ifdef SERIAL_ADDER_OVF_EN
    overflow = r_ovf;
`endif
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances);
// checks overflow too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       inValid, carryIn, outReady;
  logic [7:0] opA, opB;
  logic       inReady, outValid, carryOut;
  logic [7:0] sum;

  logic       w1_inValid, w1_carryIn, w1_outReady;
  logic [0:0] w1_opA, w1_opB, w1_sum;
  logic       w1_inReady, w1_outValid, w1_carryOut;
`ifdef SERIAL_ADDER_OVF_EN
  logic       overflow, w1_overflow;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] prev_sum;
  logic       prev_co;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .opA(opA), .opB(opB), .carryIn(carryIn), .outValid(outValid),
    .outReady(outReady), .sum(sum), .carryOut(carryOut)
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow(overflow)
`endif
  );

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rstN(rstN), .inValid(w1_inValid), .inReady(w1_inReady),
    .opA(w1_opA), .opB(w1_opB), .carryIn(w1_carryIn), .outValid(w1_outValid),
    .outReady(w1_outReady), .sum(w1_sum), .carryOut(w1_carryOut)
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow(w1_overflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction; rst_at >= 0 pulses reset after that many SHIFT edges.
  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int hold, input bit noise, input int rst_at);
    int         ea, es_signed, cyc;
    logic [7:0] es;
    logic       eco, eovf;
    ea        = int'(a) + int'(b) + int'(c);
    es        = 8'(ea);
    eco       = (ea > 255);
    es_signed = int'($signed(a)) + int'($signed(b)) + int'(c);
    eovf      = (es_signed > 127) || (es_signed < -128);

    chk("pre_inReady", inReady, 1);
    opA = a; opB = b; carryIn = c; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    chk("busy_inReady", inReady, 0);
    chk("busy_outValid", outValid, 0);
    cyc = 0;
    while (outValid !== 1'b1 && cyc < 40) begin
      chk("shift_sum_hold", sum, prev_sum);
      chk("shift_co_hold", carryOut, prev_co);
      if (noise) begin
        inValid = 1'($urandom); opA = 8'($urandom); opB = 8'($urandom); carryIn = 1'($urandom);
      end
      if (cyc == rst_at) begin
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1; inValid = 1'b0;
        chk("rst_inReady", inReady, 1);
        chk("rst_outValid", outValid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carryOut", carryOut, 0);
        prev_sum = '0; prev_co = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    inValid = 1'b0;
    chk("latency", cyc, 8);
    chk("sum", sum, es);
    chk("carryOut", carryOut, eco);
`ifdef SERIAL_ADDER_OVF_EN
    chk("overflow", overflow, eovf);
`endif
    repeat (hold) begin
      @(negedge clk);
      chk("hold_outValid", outValid, 1);
      chk("hold_sum", sum, es);
      chk("hold_carryOut", carryOut, eco);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    chk("ack_outValid", outValid, 0);
    chk("ack_inReady", inReady, 1);
    chk("idle_sum", sum, es);
    prev_sum = es; prev_co = eco;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0; opA = '0; opB = '0; carryIn = 1'b0;
    w1_inValid = 1'b0; w1_outReady = 1'b0; w1_opA = '0; w1_opB = '0; w1_carryIn = 1'b0;
    prev_sum = '0; prev_co = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    chk("reset_inReady", inReady, 1);
    chk("reset_outValid", outValid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_carryOut", carryOut, 0);

    txn8(8'hFF, 8'h01, 1'b0, 0, 1'b0, -1);
    txn8(8'h7F, 8'h01, 1'b0, 0, 1'b0, -1);
    txn8(8'h12, 8'h34, 1'b1, 5, 1'b0, -1);
    txn8(8'h55, 8'hAA, 1'b1, 1, 1'b1, -1);
    txn8(8'h3C, 8'h0F, 1'b0, 0, 1'b0, 3);
    txn8(8'h3C, 8'h0F, 1'b0, 0, 1'b0, -1);
    for (int i = 0; i < 20; i++)
      txn8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), -1);

    for (int k = 0; k < 8; k++) begin
      int v, vs;
      logic [2:0] kb;
      kb = 3'(k);
      v  = int'(kb[0]) + int'(kb[1]) + int'(kb[2]);
      vs = -int'(kb[0]) - int'(kb[1]) + int'(kb[2]);
      chk("w1_inReady", w1_inReady, 1);
      w1_opA = kb[0]; w1_opB = kb[1]; w1_carryIn = kb[2]; w1_inValid = 1'b1;
      @(negedge clk);
      w1_inValid = 1'b0;
      @(negedge clk);
      chk("w1_outValid", w1_outValid, 1);
      chk("w1_sum", w1_sum, v % 2);
      chk("w1_carryOut", w1_carryOut, (v > 1));
`ifdef SERIAL_ADDER_OVF_EN
      chk("w1_overflow", w1_overflow, (vs > 0) || (vs < -1));
`endif
      w1_outReady = 1'b1;
      @(negedge clk);
      w1_outReady = 1'b0;
      chk("w1_ack_inReady", w1_inReady, 1);
      chk("w1_ack_outValid", w1_outValid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port: rstN  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: inValid  input  1  operand set offered.
REQ-005 SHALL have port: inReady  output  1  block can accept operands.
REQ-006 SHALL have port: opA  input  WIDTH  addend A.
REQ-007 SHALL have port: opB  input  WIDTH  addend B.
REQ-008 SHALL have port: carryIn  input  1  initial carry.
REQ-009 SHALL have port: outValid  output  1  result available.
REQ-010 SHALL have port: outReady  input  1  consumer takes result.
REQ-011 SHALL have port: sum  output  WIDTH  result word.
REQ-012 SHALL have port: carryOut  output  1  final carry.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; the reset state is IDLE.
REQ-014 SHALL drive inReady=1 only in IDLE.
REQ-015 SHALL drive outValid=1 only in DONE.
REQ-016 In IDLE, inValid&inReady SHALL load opA, opB and carryIn into internal registers, clear the bit counter and enter SHIFT.
REQ-017 Each SHIFT cycle SHALL add A[0], B[0] and the carry register through one full-adder cell.
REQ-018 Each SHIFT cycle SHALL shift A and B right one bit, shift the sum bit into the result MSB (result shifts right), update the carry register, and increment the counter.
REQ-019 SHALL leave SHIFT for DONE on the cycle the counter equals WIDTH-1; outValid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-020 SHALL hold sum and carryOut stable in DONE until outValid&outReady, then return to IDLE; inReady SHALL be asserted on the following cycle (no overlap).
REQ-021 SHALL ignore inValid and operand changes outside IDLE.
REQ-022 SHALL hold sum/carryOut at the last result while in IDLE and SHIFT; the result register is updated only in SHIFT.
REQ-023 SHALL equal (opA + opB + carryIn) mod 2^WIDTH on sum, and the bit WIDTH of that sum on carryOut.
REQ-024 With WIDTH=1, SHALL perform one SHIFT cycle and enter DONE.

Reset
REQ-025 While rstN=0 at a clock edge, SHALL enter IDLE and clear sum, carryOut, counter and operand/carry registers.
REQ-026 SHALL force outValid=0 and inReady=1 on the cycle after reset, including a reset asserted during SHIFT or DONE; in-flight work is discarded.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined: SHALL add output port overflow (1 bit), registered in the last SHIFT cycle as carry-into-MSB XOR carry-out-of-MSB, valid with outValid, and cleared by reset.
REQ-028 Macro SERIAL_ADDER_OVF_EN undefined: SHALL omit the overflow port and its logic; all other behaviour SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a counter-width constant computed as clog2 of the maximum WIDTH.
REQ-030 SHALL instantiate one sub-module, serial_fa_cell (combinational 1-bit full adder: a, b, c -> sum, carryOut); all state is held in serial_adder_ctrl.

Verification
REQ-031 WIDTH=8, opA=0xFF, opB=0x01, carryIn=0 -> outValid 8 cycles after accept, sum=0x00, carryOut=1.
REQ-032 WIDTH=8, opA=0x7F, opB=0x01, carryIn=0 -> sum=0x80, carryOut=0, overflow=1 (with macro); opA=0x12, opB=0x34, carryIn=1 -> sum=0x47, carryOut=0, overflow=0.
REQ-033 outReady held 0 for 5 cycles in DONE -> sum and outValid stable throughout; release -> IDLE next cycle, inReady=1.
REQ-034 New operands on inValid=1 during SHIFT -> ignored; the result reflects the first operand set only.
REQ-035 rstN=0 for one cycle at SHIFT cycle 3 -> next cycle IDLE, sum=0, carryOut=0, outValid=0; a subsequent transaction completes correctly.
REQ-036 WIDTH=1, opA=1, opB=1, carryIn=1 -> outValid 1 cycle after accept, sum=1, carryOut=1.
